// File: rtl/face_classifier_mul_arb_if.sv
// face_classifier_mul_arb_if: requester, shared-multiplier and response signals of the multiplier arbiter
interface face_classifier_mul_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 13
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [DATA_WIDTH-1:0]         mul_din0;
  logic [DATA_WIDTH-1:0]         mul_din1;
  logic [DATA_WIDTH-1:0]         mul_dout;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [1:0]                    in_flight;
  modport master (
    output req_valid, req_a, req_b, mul_dout,
    input  req_ready, mul_din0, mul_din1, rsp_valid, rsp_data, in_flight
  );
  modport slave (
    input  req_valid, req_a, req_b, mul_dout,
    output req_ready, mul_din0, mul_din1, rsp_valid, rsp_data, in_flight
  );
endinterface

// File: rtl/face_classifier_mul_arb.sv
// face_classifier_mul_arb: round-robin sharing of one signed multiplier, two-stage tagged pipeline
module face_classifier_mul_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 13
) (
  input logic ap_clk,
  input logic ap_rst_n,
  input logic ap_ce,
  face_classifier_mul_arb_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int W  = DATA_WIDTH;
  logic [NUM_REQ-1:0] rot;
  logic [PW-1:0]      off, gidx, ptr_q, ptr_d, s1_idx_q, s2_idx_q;
  logic [PW:0]        sum;
  logic               gv, xfer, s1_v_q, s2_v_q;
  logic [W-1:0]       a_sel, b_sel, din0_q, din1_q, rsp_q;
  logic [1:0]         inf_d, inf_q;
  // rotate valids so bit 0 is the requester at ptr; lowest set bit wins
  always_comb begin
    rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> ptr_q);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = PW'(k);
    gv = |rot;
    sum = {1'b0, ptr_q} + {1'b0, off};
    gidx = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
    xfer = gv & ap_ce & ap_rst_n;
    bus.req_ready = xfer ? NUM_REQ'(1) << gidx : '0;
    ptr_d = xfer ? ((gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1) : ptr_q;
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (gidx == PW'(k)) begin
        a_sel = bus.req_a[k*W +: W];
        b_sel = bus.req_b[k*W +: W];
      end
    inf_d = {1'b0, xfer} + {1'b0, s1_v_q};
    bus.rsp_valid = (ap_ce & s2_v_q) ? NUM_REQ'(1) << s2_idx_q : '0;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      ptr_q    <= '0;
      s1_v_q   <= 1'b0;
      s1_idx_q <= '0;
      s2_v_q   <= 1'b0;
      s2_idx_q <= '0;
      din0_q   <= '0;
      din1_q   <= '0;
      rsp_q    <= '0;
      inf_q    <= '0;
    end else if (ap_ce) begin
      ptr_q  <= ptr_d;
      s1_v_q <= xfer;
      if (xfer) begin
        s1_idx_q <= gidx;
        din0_q   <= a_sel;
        din1_q   <= b_sel;
      end
      s2_v_q   <= s1_v_q;
      s2_idx_q <= s1_idx_q;
      if (s1_v_q) rsp_q <= bus.mul_dout;
      inf_q <= inf_d;
    end
  assign bus.mul_din0  = din0_q;
  assign bus.mul_din1  = din1_q;
  assign bus.rsp_data  = rsp_q;
  assign bus.in_flight = inf_q;
endmodule

// File: tb/tb_face_classifier_mul_arb.sv
// tb_face_classifier_mul_arb: directed and random traffic against a queue-based reference model
module tb_face_classifier_mul_arb;
  localparam int N = 4;
  localparam int W = 13;
  typedef struct {
    int           idx;
    logic [W-1:0] p;
    int           ts;
  } op_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ce = 1'b0;
  logic [N-1:0] v;
  logic [W-1:0] a [N];
  logic [W-1:0] b [N];
  op_t q[$];
  int ptr, ecnt, checks, errors;
  face_classifier_mul_arb_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();
  face_classifier_mul_arb #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_ce(ce), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] p;
    p = $signed(x) * $signed(y);
    return p[W-1:0];
  endfunction
  assign bus.mul_dout = mul(bus.mul_din0, bus.mul_din1);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive();
    bus.req_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = a[i];
      bus.req_b[i*W +: W] = b[i];
    end
  endtask
  task automatic fill(input int pct);
    for (int i = 0; i < N; i++)
      if (!v[i] && $urandom_range(0, 99) < pct) begin
        v[i] = 1'b1;
        a[i] = W'($urandom);
        b[i] = W'($urandom);
      end
  endtask
  task automatic step(input logic c);
    int g, exp_if;
    logic hit;
    logic [31:0] exp_rv, exp_rd;
    ce = c;
    drive();
    #1;
    g = -1;
    if (c) for (int k = 0; k < N; k++) if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
    chk("req_ready", 32'(bus.req_ready), g < 0 ? 32'd0 : 32'd1 << g);
    hit = 1'b0;
    exp_if = 0;
    exp_rv = 0;
    exp_rd = 0;
    foreach (q[i]) begin
      if (ecnt - q[i].ts inside {[1:2]}) exp_if++;
      if (c && ecnt - q[i].ts == 2) begin
        hit = 1'b1;
        exp_rv = 32'd1 << q[i].idx;
        exp_rd = 32'(q[i].p);
      end
    end
    chk("rsp_valid", 32'(bus.rsp_valid), exp_rv);
    if (hit) chk("rsp_data", 32'(bus.rsp_data), exp_rd);
    chk("in_flight", 32'(bus.in_flight), 32'(exp_if));
    @(posedge clk);
    if (c) begin
      if (g >= 0) begin
        q.push_back('{g, mul(a[g], b[g]), ecnt});
        ptr = (g + 1) % N;
        v[g] = 1'b0;
      end
      ecnt++;
      while (q.size() > 0 && ecnt - q[0].ts > 2) q.pop_front();
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_mul_din0", 32'(bus.mul_din0), 0);
    chk("rst_mul_din1", 32'(bus.mul_din1), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_in_flight", 32'(bus.in_flight), 0);
    q.delete();
    ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    ptr = 0;
    ecnt = 0;
    v = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    drive();
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      fill(100);
      step(1'b1);
    end
    v = '0;
    step(1'b1);
    step(1'b1);
    v[2] = 1'b1;
    a[2] = 13'd5;
    b[2] = 13'h1FFD;
    step(1'b1);
    step(1'b1);
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
    chk("single_rsp_data", 32'(bus.rsp_data), 32'h1FF1);
    v[0] = 1'b1;
    a[0] = 13'd100;
    b[0] = 13'd100;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("trunc_10000", 32'(bus.rsp_data), 32'd1808);
    v[0] = 1'b1;
    a[0] = 13'h1000;
    b[0] = 13'h1FFF;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("trunc_neg4096", 32'(bus.rsp_data), 32'h1000);
    v[2] = 1'b1;
    step(1'b1);
    v[1] = 1'b1;
    v[3] = 1'b1;
    a[1] = W'($urandom);
    a[3] = W'($urandom);
    step(1'b1);
    step(1'b1);
    v[3] = 1'b1;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    v[0] = 1'b1;
    a[0] = W'($urandom);
    b[0] = W'($urandom);
    step(1'b1);
    fill(100);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    v = '0;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    fill(100);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    do_reset();
    v = '0;
    v[1] = 1'b1;
    a[1] = W'($urandom);
    b[1] = W'($urandom);
    for (int i = 0; i < 4; i++) step(1'b1);
    for (int i = 0; i < 400; i++) begin
      fill(50);
      step($urandom_range(0, 4) != 0);
    end
    v = '0;
    for (int i = 0; i < 3; i++) step(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/face_classifier_mul_arb.md
# face_classifier_mul_arb

Round-robin arbiter and sequencer that shares one combinational signed multiplier (13x13, product truncated to 13 bits) between `NUM_REQ` requesters in the face classifier datapath. The block accepts at most one operand pair per cycle through valid/ready handshakes. It registers the winning pair onto the multiplier inputs, captures the product one cycle later, and returns it with a one-hot response valid to the requester that issued it. It sits between the classifier's MAC lanes and the single shared multiplier instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default 13: operand and product width, signed.

Ports:
- `ap_clk`, in, 1: clock. All state changes on the rising edge.
- `ap_rst_n`, in, 1: reset, asynchronous and active-low.
- `ap_ce`, in, 1: clock enable. Low freezes the whole block.
- `req_valid`, in, NUM_REQ: per-requester operand valid.
- `req_ready`, out, NUM_REQ: per-requester accept. One-hot or zero, combinational.
- `req_a`, in, NUM_REQ*DATA_WIDTH: operand A. Requester i drives bits [i*W +: W].
- `req_b`, in, NUM_REQ*DATA_WIDTH: operand B, same packing as `req_a`.
- `mul_din0`, out, DATA_WIDTH: registered operand A to the shared multiplier.
- `mul_din1`, out, DATA_WIDTH: registered operand B to the shared multiplier.
- `mul_dout`, in, DATA_WIDTH: combinational product returned by the multiplier.
- `rsp_valid`, out, NUM_REQ: one-hot result strobe, one cycle per result.
- `rsp_data`, out, DATA_WIDTH: result bus shared by all requesters.
- `in_flight`, out, 2: number of accepted operations not yet returned (0..2).

## Operation
- **Arbitration**
  - Round-robin pointer `ptr`, range 0..NUM_REQ-1, reset value 0.
  - When `ap_ce`=1, grant goes to the first i with `req_valid[i]`=1, searching from `ptr` upward and wrapping at NUM_REQ-1.
  - `req_ready` is the one-hot grant. It is 0 when `ap_ce`=0 or when no request is valid.
  - On a grant to index g, `ptr` becomes (g+1) mod NUM_REQ. With no grant, `ptr` holds.
- **Handshake**
  - Transfer happens when `req_valid[i]` & `req_ready[i]` are both 1.
  - A requester holds `req_valid` and its operands stable until the transfer.
  - `req_ready` never depends on `rsp_*`.
  - Responses have no backpressure: a requester must consume `rsp_valid` in the cycle it is asserted.
- **Pipeline** (all registers advance only when `ap_ce`=1)
  - Stage 1, on transfer:
    - `mul_din0`/`mul_din1` load the granted operands.
    - The s1 tag (valid + index) loads the grant.
    - With no transfer, the s1 tag valid clears and `mul_din0`/`mul_din1` hold their values.
  - Stage 2:
    - `rsp_data` loads `mul_dout` when the s1 tag is valid, otherwise it holds.
    - The s2 tag loads the s1 tag.
  - `rsp_valid` = one-hot of the s2 index when the s2 tag is valid and `ap_ce`=1, otherwise 0.
- **Arithmetic**
  - Result = low DATA_WIDTH bits of signed(a)*signed(b), i.e. two's-complement wrap with no saturation.
  - The block passes `mul_dout` through unchanged.
- **`in_flight`** = s1 valid + s2 valid, registered. It only counts operations; it never gates arbitration.
- **Reset** (asynchronous, `ap_rst_n`=0):
  - `ptr`=0, both tags invalid, `mul_din0`=`mul_din1`=0, `rsp_data`=0, `rsp_valid`=0, `in_flight`=0.
  - `req_ready`=0 while reset is asserted.
  - Operations in flight at reset are dropped and never responded to.

## Timing
- Throughput: one operation per cycle, sustained.
- Latency: a transfer in cycle N gives `rsp_valid` and `rsp_data` in cycle N+2. `ap_ce`-low cycles extend this one-for-one.
- `ap_ce` low:
  - Pipeline, `ptr` and `rsp_data` hold.
  - `rsp_valid` is forced to 0.
  - A result pending in s2 is presented when `ap_ce` returns high, exactly once.
- Simultaneous events:
  - A new transfer into s1 and an s2 response in the same cycle are independent.
  - The same requester may be granted in consecutive cycles when it is the only one valid.
- Combinational paths: `req_valid` → `req_ready`, and `ap_ce` → `req_ready`/`rsp_valid`. All other outputs are registered.

## Test plan
- **Reset:** assert `ap_rst_n`=0 mid-stream with 2 operations in flight. All outputs read 0 immediately. After release, the first request gets its response and the dropped operations never appear.
- **Single op:** requester 2 sends a=5, b=-3. `req_ready[2]`=1 in the same cycle. Two cycles later `rsp_valid`=4'b0100 and `rsp_data`=-15 (13'h1FF1).
- **Truncation:** a=100, b=100. `rsp_data` = 10000 mod 8192 = 1808. Also a=-4096, b=-1 → -4096 (13'h1000).
- **Fairness:** all 4 requesters valid continuously for 8 cycles from reset. Grants run 0,1,2,3,0,1,2,3, and responses come back in that order, one per cycle, starting at cycle 2.
- **Wrap and skip:** `ptr`=3, only requesters 1 and 3 valid. Grants go 3, then 1, then 3.
- **Clock enable:** pull `ap_ce` low for 3 cycles starting the cycle after a transfer. There are no grants and no `rsp_valid` during the stall. The response arrives 2 enabled cycles after the transfer, exactly once, with the correct product.
